lsu_mem_initiator: RTL and testbench



---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_mem_initiator_if.sv | 41 ++++
 rtl/lsu_align.sv | 35 +++
 rtl/lsu_mem_initiator.sv | 129 ++++++++++++
 tb/tb_lsu_mem_initiator.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory initiator:
// access sizes, FSM states, byte-mask seeds and the alignment check.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Requests that must be rejected without touching memory.
    function automatic logic is_bad_access(input lsu_size_e size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Core-side request/response and memory-side bus of the load/store initiator.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid and its payload are held stable until then. mem_resp_valid is a one-cycle pulse.
interface lsu_mem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sext;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    // master: the initiator block itself; slave: core plus memory around it.
    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_sext,
        input  resp_ready, mem_ready, mem_resp_valid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_sext,
        output resp_ready, mem_ready, mem_resp_valid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store data shift and byte mask, load extract and extend.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        sext,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_sh,
    output logic [3:0]  wmask,
    output logic [31:0] rdata_ext
);

    logic [31:0] rdata_sh;

    always_comb begin
        wdata_sh  = wdata << {off, 3'b000};
        rdata_sh  = rdata >> {off, 3'b000};
        wmask     = MASK_W;
        rdata_ext = rdata_sh;
        case (size)
            SZ_B: begin
                wmask     = MASK_B << off;
                rdata_ext = {{24{sext & rdata_sh[7]}}, rdata_sh[7:0]};
            end
            SZ_H: begin
                wmask     = MASK_H << off;
                rdata_ext = {{16{sext & rdata_sh[15]}}, rdata_sh[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator: latches one core request, runs the memory
// handshake, waits for the response (with optional timeout) and returns one result.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    lsu_mem_initiator_if.master bus,
    output lsu_state_e          fsm_state
);

    lsu_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             lat_wen, lat_wen_nxt;
    logic [31:0]      lat_addr, lat_addr_nxt;
    logic [31:0]      lat_wdata, lat_wdata_nxt;
    lsu_size_e        lat_size, lat_size_nxt;
    logic             lat_sext, lat_sext_nxt;
    logic [31:0]      rdata_r, rdata_nxt;
    logic             err_r, err_nxt;

    logic [31:0]      wdata_sh;
    logic [3:0]       wmask;
    logic [31:0]      rdata_ext;
    logic             hit_timeout;
    logic             mem_done;

    lsu_align u_align (
        .size      (lat_size),
        .sext      (lat_sext),
        .off       (lat_addr[1:0]),
        .wdata     (lat_wdata),
        .rdata     (bus.mem_rdata),
        .wdata_sh  (wdata_sh),
        .wmask     (wmask),
        .rdata_ext (rdata_ext)
    );

    assign cnt_inc     = cnt + 1'b1;
    assign hit_timeout = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    // A response in REQ only counts when the request is accepted in the same cycle.
    assign mem_done    = bus.mem_resp_valid && ((state == WAIT) || bus.mem_ready);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lat_wen_nxt   = lat_wen;
        lat_addr_nxt  = lat_addr;
        lat_wdata_nxt = lat_wdata;
        lat_size_nxt  = lat_size;
        lat_sext_nxt  = lat_sext;
        rdata_nxt     = rdata_r;
        err_nxt       = err_r;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    lat_wen_nxt   = bus.req_wen;
                    lat_addr_nxt  = bus.req_addr;
                    lat_wdata_nxt = bus.req_wdata;
                    lat_size_nxt  = lsu_size_e'(bus.req_size);
                    lat_sext_nxt  = bus.req_sext;
                    cnt_nxt       = '0;
                    rdata_nxt     = '0;
                    err_nxt       = is_bad_access(lsu_size_e'(bus.req_size), bus.req_addr[1:0]);
                    state_nxt     = err_nxt ? RESP : REQ;
                end
            end
            REQ, WAIT: begin
                cnt_nxt = cnt_inc;
                // A real response wins over a timeout landing in the same cycle.
                if (mem_done) begin
                    rdata_nxt = lat_wen ? 32'h0 : rdata_ext;
                    err_nxt   = 1'b0;
                    state_nxt = RESP;
                end else if (hit_timeout) begin
                    rdata_nxt = 32'h0;
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end else if ((state == REQ) && bus.mem_ready) begin
                    state_nxt = WAIT;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_wen   <= 1'b0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_size  <= SZ_B;
            lat_sext  <= 1'b0;
            rdata_r   <= 32'h0;
            err_r     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lat_wen   <= lat_wen_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_wdata <= lat_wdata_nxt;
            lat_size  <= lat_size_nxt;
            lat_sext  <= lat_sext_nxt;
            rdata_r   <= rdata_nxt;
            err_r     <= err_nxt;
        end
    end

    // Payload comes straight from the latched request, so it cannot move during REQ.
    assign bus.req_ready  = rst_n && (state == IDLE);
    assign bus.mem_valid  = (state == REQ);
    assign bus.mem_wen    = lat_wen;
    assign bus.mem_addr   = {lat_addr[31:2], 2'b00};
    assign bus.mem_wdata  = wdata_sh;
    assign bus.mem_wmask  = {4'b0000, lat_wen ? wmask : 4'b0000};
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_r;
    assign bus.resp_err   = err_r;
    assign fsm_state      = state;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: drives requests, plays the memory responder
// and checks results against an expected-response queue.
module tb_lsu_mem_initiator;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_initiator_if bus();
  lsu_state_e fsm_state;

  lsu_mem_initiator #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_rdata_q[$];
  logic        exp_err_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [1:0] size, input logic sext,
                                           input logic [1:0] off, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    int o;
    o = int'(off);
    b = w[8*o +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      2'd0:    return sext ? {{24{b[7]}}, b} : {24'h0, b};
      2'd1:    return sext ? {{16{h[15]}}, h} : {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [7:0] exp_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 8'h01 << off;
      2'd1:    return 8'h03 << off;
      default: return 8'h0F;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [1:0] off,
                                            input logic [31:0] w);
    int o;
    o = int'(off);
    case (size)
      2'd0:    return {24'h0, w[7:0]} << (8*o);
      2'd1:    return {16'h0, w[15:0]} << (8*o);
      default: return w;
    endcase
  endfunction

  // Starts at a negedge with the block idle; d = extra cycles before mem_ready,
  // r = cycles after acceptance until the response (0 = same cycle).
  task automatic run_txn(input string tag, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic sext,
                         input int d, input int r, input logic respond,
                         input logic [31:0] rdata, input int exp_lat, input int exp_vcnt);
    logic [31:0] e_rd;
    logic        e_err;
    logic        bad_req;
    logic        accepted;
    logic        seen;
    int          vcnt;
    int          wcnt;
    int          cyc;
    bad_req = (size == 2'd3) || ((size == 2'd1) && addr[0]) ||
              ((size == 2'd2) && (addr[1:0] != 2'b00));
    if (bad_req || !respond) begin
      e_rd = 32'h0; e_err = 1'b1;
    end else if (wen) begin
      e_rd = 32'h0; e_err = 1'b0;
    end else begin
      e_rd = exp_load(size, sext, addr[1:0], rdata); e_err = 1'b0;
    end
    exp_rdata_q.push_back(e_rd);
    exp_err_q.push_back(e_err);

    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_size  = size;
    bus.req_sext  = sext;
    bus.req_valid = 1'b1;
    bus.mem_rdata = rdata;
    check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);

    vcnt = 0; wcnt = 0; cyc = 0; accepted = 1'b0; seen = 1'b0;
    @(negedge clk);
    cyc = 1;
    bus.req_valid = 1'b0;
    while (!seen && cyc < 40) begin
      bus.mem_ready = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (bus.resp_valid) begin
        seen = 1'b1;
      end else begin
        if (bus.mem_valid) begin
          vcnt++;
          check({tag, ".mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
          check({tag, ".mem_wen"}, 32'(bus.mem_wen), 32'(wen));
          if (wen) begin
            check({tag, ".mem_wdata"}, bus.mem_wdata, exp_wdata(size, addr[1:0], wdata));
            check({tag, ".mem_wmask"}, 32'(bus.mem_wmask), 32'(exp_mask(size, addr[1:0])));
          end
          if (vcnt > d) begin
            bus.mem_ready = 1'b1;
            accepted = 1'b1;
            if (respond && r == 0) bus.mem_resp_valid = 1'b1;
          end
        end else if (accepted) begin
          wcnt++;
          if (respond && wcnt == r) bus.mem_resp_valid = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.mem_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;

    check({tag, ".resp_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, ".mem_valid_cycles"}, 32'(vcnt), 32'(exp_vcnt));
    e_rd  = exp_rdata_q.pop_front();
    e_err = exp_err_q.pop_front();
    check({tag, ".resp_rdata"}, bus.resp_rdata, e_rd);
    check({tag, ".resp_err"}, 32'(bus.resp_err), 32'(e_err));

    // Hold off the core for a cycle; the response must stay put.
    @(negedge clk);
    check({tag, ".resp_hold_valid"}, 32'(bus.resp_valid), 32'd1);
    check({tag, ".resp_hold_rdata"}, bus.resp_rdata, e_rd);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, ".back_idle"}, 32'(fsm_state), 32'(IDLE));
    check({tag, ".resp_dropped"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.req_size = 2'd0; bus.req_sext = 1'b0; bus.resp_ready = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst.req_ready", 32'(bus.req_ready), 32'd0);
    check("rst.mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst.mem_wen", 32'(bus.mem_wen), 32'd0);
    check("rst.mem_addr", bus.mem_addr, 32'h0);
    check("rst.mem_wdata", bus.mem_wdata, 32'h0);
    check("rst.mem_wmask", 32'(bus.mem_wmask), 32'h0);
    check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst.resp_rdata", bus.resp_rdata, 32'h0);
    check("rst.resp_err", 32'(bus.resp_err), 32'd0);
    check("rst.state", 32'(fsm_state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.req_ready_after", 32'(bus.req_ready), 32'd1);

    run_txn("lw",      1'b0, 32'h8000_0004, 32'h0,         2'd2, 1'b0, 0, 0, 1'b1, 32'hDEAD_BEEF, 2, 1);
    run_txn("lb_s",    1'b0, 32'h8000_0003, 32'h0,         2'd0, 1'b1, 0, 0, 1'b1, 32'h8012_3456, 2, 1);
    run_txn("lb_u",    1'b0, 32'h8000_0003, 32'h0,         2'd0, 1'b0, 0, 0, 1'b1, 32'h8012_3456, 2, 1);
    run_txn("sh",      1'b1, 32'h8000_0002, 32'h1234_ABCD, 2'd1, 1'b0, 3, 0, 1'b1, 32'h5555_5555, 5, 4);
    run_txn("mis_w",   1'b0, 32'h8000_0001, 32'h0,         2'd2, 1'b0, 0, 0, 1'b1, 32'h0,         1, 0);
    run_txn("size3",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 1'b0, 0, 0, 1'b1, 32'h0,         1, 0);
    run_txn("mis_h",   1'b0, 32'h8000_0003, 32'h0,         2'd1, 1'b1, 0, 0, 1'b1, 32'h0,         1, 0);
    run_txn("lh_wait", 1'b0, 32'h8000_0012, 32'h0,         2'd1, 1'b1, 0, 2, 1'b1, 32'h9ABC_1234, 4, 1);
    run_txn("lhu",     1'b0, 32'h8000_0010, 32'h0,         2'd1, 1'b0, 0, 1, 1'b1, 32'h9ABC_F00D, 3, 1);
    run_txn("sb",      1'b1, 32'h8000_0021, 32'h0000_00A5, 2'd0, 1'b0, 1, 1, 1'b1, 32'h0,         4, 2);
    run_txn("sw",      1'b1, 32'h8000_0040, 32'hCAFE_F00D, 2'd2, 1'b0, 0, 0, 1'b1, 32'h0,         2, 1);

    run_txn("tmo",     1'b0, 32'h8000_0008, 32'h0,         2'd2, 1'b0, 0, 0, 1'b0, 32'h1111_1111, 5, 1);
    // A late response after the timeout must not produce anything.
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata = 32'h2222_2222;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("late.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("late.state", 32'(fsm_state), 32'(IDLE));
    check("late.mem_valid", 32'(bus.mem_valid), 32'd0);
    run_txn("after_tmo", 1'b0, 32'h8000_000C, 32'h0, 2'd2, 1'b0, 1, 0, 1'b1, 32'h3333_4444, 3, 2);

    // Reset while waiting for the memory response.
    bus.req_wen = 1'b0; bus.req_addr = 32'h8000_0010; bus.req_size = 2'd2; bus.req_sext = 1'b0;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    check("rstw.in_wait", 32'(fsm_state), 32'(WAIT));
    rst_n = 1'b0;
    @(negedge clk);
    check("rstw.state", 32'(fsm_state), 32'(IDLE));
    check("rstw.req_ready_low", 32'(bus.req_ready), 32'd0);
    check("rstw.mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rstw.mem_addr", bus.mem_addr, 32'h0);
    check("rstw.resp_valid", 32'(bus.resp_valid), 32'd0);
    rst_n = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("rstw.after_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rstw.after_state", 32'(fsm_state), 32'(IDLE));
    check("rstw.after_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    check("rstw.still_no_resp", 32'(bus.resp_valid), 32'd0);
    check("rstw.resp_rdata", bus.resp_rdata, 32'h0);

    run_txn("post_rst", 1'b0, 32'h8000_0004, 32'h0, 2'd0, 1'b1, 0, 0, 1'b1, 32'h0000_7F00, 2, 1);
    check("queue_empty", 32'(exp_rdata_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
